// File: rtl/regfile_mp.sv
// Multi-port register file with pending-write scoreboard; 0-cycle reads, 1-cycle writes and scoreboard, no backpressure.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter int ZERO_REG   = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_READ*AW-1:0]          raddr,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rdata,
  output logic [NUM_READ-1:0]             rbusy,
  input  logic [NUM_WRITE-1:0]            wen,
  input  logic [NUM_WRITE*AW-1:0]         waddr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wdata,
  input  logic                            issue_en,
  input  logic [AW-1:0]                   issue_addr,
  output logic [DEPTH-1:0]                busy_vec
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_pend;
  logic [DEPTH-1:0]      w_pend_nxt;

  // Clear for retiring writes first, then set for the new issue so a
  // same-cycle issue to the retiring register leaves it pending.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (wen[j]) w_pend_nxt[waddr[j*AW +: AW]] = 1'b0;
    end
    if (issue_en && !(ZR && issue_addr == '0)) w_pend_nxt[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) r_mem[r] <= '0;
      r_pend <= '0;
    end else begin
      // Later iterations override earlier ones: higher write port wins.
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (wen[j] && !(ZR && waddr[j*AW +: AW] == '0))
          r_mem[waddr[j*AW +: AW]] <= wdata[j*DATA_WIDTH +: DATA_WIDTH];
      end
      r_pend <= w_pend_nxt;
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      logic [AW-1:0] w_ra;
      w_ra = raddr[i*AW +: AW];
      rdata[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_ra];
      rbusy[i] = r_pend[w_ra];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (wen[j] && waddr[j*AW +: AW] == w_ra) begin
          rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata[j*DATA_WIDTH +: DATA_WIDTH];
          rbusy[i] = 1'b0;
        end
      end
`endif
      if (ZR && w_ra == '0) begin
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        rbusy[i] = 1'b0;
      end
    end
  end

  assign busy_vec = r_pend;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp (default parameters): directed scenarios then random traffic vs a reference model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [1:0]  wen;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [31:0] busy_vec;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [32];
  bit          m_pend [32];

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .issue_en(issue_en),
    .issue_addr(issue_addr), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_mem[r]  = 32'h0;
      m_pend[r] = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_rdata(input logic [4:0] a);
    logic [31:0] v;
    v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 1; j >= 0; j--) begin
      if (wen[j] && waddr[j*5 +: 5] == a) begin
        v = wdata[j*32 +: 32];
        break;
      end
    end
`endif
    if (a == 5'd0) v = 32'h0;
    return v;
  endfunction

  function automatic logic exp_rbusy(input logic [4:0] a);
    logic b;
    b = m_pend[a];
`ifdef REGFILE_BYPASS_EN
    if ((wen[0] && waddr[4:0] == a) || (wen[1] && waddr[9:5] == a)) b = 1'b0;
`endif
    if (a == 5'd0) b = 1'b0;
    return b;
  endfunction

  function automatic logic [31:0] exp_busy_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_pend[r];
    return v;
  endfunction

  // Reference state update at the clock edge, stated register by register.
  task automatic model_edge();
    logic [31:0] final_data;
    logic        written;
    for (int r = 1; r < 32; r++) begin
      written = 1'b0;
      final_data = m_mem[r];
      if (wen[0] && waddr[4:0] == r) begin written = 1'b1; final_data = wdata[31:0];  end
      if (wen[1] && waddr[9:5] == r) begin written = 1'b1; final_data = wdata[63:32]; end
      m_mem[r] = final_data;
      if (issue_en && issue_addr == r) m_pend[r] = 1'b1;
      else if (written)                m_pend[r] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wen = 2'b00;
    issue_en = 1'b0;
  endtask

  task automatic check_all(input string tag);
    #3;
    for (int i = 0; i < 2; i++) begin
      check({tag, "_rdata"}, rdata[i*32 +: 32], exp_rdata(raddr[i*5 +: 5]));
      check({tag, "_rbusy"}, {31'h0, rbusy[i]}, {31'h0, exp_rbusy(raddr[i*5 +: 5])});
    end
    check({tag, "_busy_vec"}, busy_vec, exp_busy_vec());
  endtask

  initial begin
    rst_n = 1'b0;
    raddr = {5'd2, 5'd1};
    wen = 2'b00; waddr = '0; wdata = '0;
    issue_en = 1'b0; issue_addr = '0;
    model_reset();
    #3;
    check("por_busy_vec", busy_vec, 32'h0);
    check("por_rdata", rdata[31:0], 32'h0);
    #9 rst_n = 1'b1;
    #4;  // now at posedge+1

    // Load r5, mark r12 pending, then reset mid-cycle.
    wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEAD_BEEF};
    issue_en = 1'b1; issue_addr = 5'd12;
    tick();
    idle(); raddr = {5'd12, 5'd5};
    #3;
    check("r5_loaded", rdata[31:0], 32'hDEAD_BEEF);
    check("r12_pending", {31'h0, busy_vec[12]}, 32'h1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_rdata", rdata[31:0], 32'h0);
    check("async_rst_busy_vec", busy_vec, 32'h0);
    #2 rst_n = 1'b1;
    #2;  // posedge+1

    // Dual-port write conflict on r7.
    wen = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h2222_2222, 32'h1111_1111};
    tick();
    idle(); raddr = {5'd7, 5'd7};
    #3;
    check("conflict_r7", rdata[31:0], 32'h2222_2222);
    check_all("conflict");
    tick();

    // Register zero: write and issue are both discarded.
    wen = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'hFFFF_FFFF};
    issue_en = 1'b1; issue_addr = 5'd0; raddr = {5'd0, 5'd0};
    tick();
    idle();
    #3;
    check("zero_rdata", rdata[31:0], 32'h0);
    check("zero_rbusy", {31'h0, rbusy[0]}, 32'h0);
    check("zero_busy_vec0", {31'h0, busy_vec[0]}, 32'h0);
    tick();

    // Scoreboard on r3.
    issue_en = 1'b1; issue_addr = 5'd3;
    tick();
    idle(); raddr = {5'd3, 5'd3};
    #3;
    check("sb_issue", {31'h0, busy_vec[3]}, 32'h1);
    check("sb_issue_rbusy", {31'h0, rbusy[1]}, 32'h1);
    tick();
    wen = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h0000_0033};
    issue_en = 1'b1; issue_addr = 5'd3;
    tick();
    idle();
    #3;
    check("sb_write_and_issue", {31'h0, busy_vec[3]}, 32'h1);
    wen = 2'b10; waddr = {5'd3, 5'd0}; wdata = {32'h0000_0034, 32'h0};
    tick();
    idle();
    #3;
    check("sb_write_clears", {31'h0, busy_vec[3]}, 32'h0);
    check("sb_r3_data", rdata[31:0], 32'h0000_0034);
    tick();

    // Forwarding scenario on r9.
    wen = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h0000_1234};
    tick();
    idle(); issue_en = 1'b1; issue_addr = 5'd9;
    tick();
    idle();
    wen = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h0000_00A5};
    raddr = {5'd9, 5'd9};
    #3;
`ifdef REGFILE_BYPASS_EN
    check("byp_rdata", rdata[31:0], 32'h0000_00A5);
    check("byp_rbusy", {31'h0, rbusy[0]}, 32'h0);
`else
    check("nobyp_rdata", rdata[31:0], 32'h0000_1234);
    check("nobyp_rbusy", {31'h0, rbusy[0]}, 32'h1);
`endif
    tick();
    idle();
    #3;
    check("byp_next_rdata", rdata[31:0], 32'h0000_00A5);
    check("byp_next_rbusy", {31'h0, rbusy[0]}, 32'h0);
    tick();

    // Random traffic; small address range half the time to force collisions.
    for (int n = 0; n < 400; n++) begin
      logic narrow;
      narrow = $urandom_range(0, 1) == 1;
      wen = 2'($urandom_range(0, 3));
      for (int j = 0; j < 2; j++) begin
        waddr[j*5 +: 5] = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        raddr[j*5 +: 5] = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        wdata[j*32 +: 32] = $urandom;
      end
      issue_en = $urandom_range(0, 2) != 0;
      issue_addr = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      check_all("rand");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
